// File: rtl/exu_mdv.sv
// =============================================================================
//  Module   : exu_mdv
//  Brief    : Iterative radix-2 RV32M multiply/divide unit with val/rdy in/out.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module exu_mdv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs_ex4md_val,
    output logic             hs_md4ex_rdy,
    input  logic [2:0]       i_mdv_op,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [4:0]       i_rd_idx,
    input  logic             i_flush,
    output logic             hs_md4wb_val,
    input  logic             hs_wb4md_rdy,
    output logic [XLEN-1:0]  o_rd,
    output logic [4:0]       o_rd_idx,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_prod;   // product, or {unused, quotient} when dividing
    logic [XLEN-1:0]     r_rem;

    logic                w_accept;
    logic                w_sgn_a_en;
    logic                w_sgn_b_en;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_div0;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_result;

    assign hs_md4ex_rdy = (r_state == S_IDLE) & ~rst;
    assign hs_md4wb_val = (r_state == S_DONE);
    assign o_busy       = (r_state != S_IDLE);
    assign w_accept     = hs_ex4md_val & hs_md4ex_rdy & ~i_flush;

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2
    assign w_sgn_a_en = (i_mdv_op == 3'd1) | (i_mdv_op == 3'd2) |
                        (i_mdv_op == 3'd4) | (i_mdv_op == 3'd6);
    assign w_sgn_b_en = (i_mdv_op == 3'd1) | (i_mdv_op == 3'd4) | (i_mdv_op == 3'd6);
    assign w_neg_a    = w_sgn_a_en & i_rs1[XLEN-1];
    assign w_neg_b    = w_sgn_b_en & i_rs2[XLEN-1];
    assign w_abs_a    = w_neg_a ? (~i_rs1 + 1'b1) : i_rs1;
    assign w_abs_b    = w_neg_b ? (~i_rs2 + 1'b1) : i_rs2;

    assign w_div0    = i_mdv_op[2] & (i_rs2 == '0);
    assign w_ovf     = i_mdv_op[2] & ~i_mdv_op[0] &
                       (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2 == '1);
    assign w_special = w_div0 | w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = i_mdv_op[1] ? i_rs1 : '1;
        else if (w_ovf)
            w_special_res = i_mdv_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    assign w_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_b};
    assign w_shift = {r_rem, r_prod[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};

    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? (~r_prod + 1'b1) : r_prod;
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? (~r_prod[XLEN-1:0] + 1'b1) : r_prod[XLEN-1:0];
    assign w_rem_fix  = r_sign_a ? (~r_rem + 1'b1) : r_rem;

    always_comb begin
        w_result = '0;
        case (r_op)
            3'd0:                w_result = w_prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_result = w_prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_result = w_quo_fix;
            default:             w_result = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CNT_W'(XLEN-1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: if (hs_wb4md_rdy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b      <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            o_rd     <= '0;
            o_rd_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_op     <= i_mdv_op;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_b      <= w_abs_b;
                        r_prod   <= {{XLEN{1'b0}}, w_abs_a};
                        r_rem    <= '0;
                        o_rd_idx <= i_rd_idx;
                        if (w_special)
                            o_rd <= w_special_res;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op[2]) begin
                        // restoring step: keep the trial subtraction when it stays non-negative
                        if (!w_diff[XLEN]) begin
                            r_rem              <= w_diff[XLEN-1:0];
                            r_prod[XLEN-1:0]   <= {r_prod[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem              <= w_shift[XLEN-1:0];
                            r_prod[XLEN-1:0]   <= {r_prod[XLEN-2:0], 1'b0};
                        end
                    end else if (r_prod[0]) begin
                        r_prod <= {w_sum, r_prod[XLEN-1:1]};
                    end else begin
                        r_prod <= {1'b0, r_prod[2*XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    if (!i_flush)
                        o_rd <= w_result;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exu_mdv.sv
// =============================================================================
//  Module   : tb_exu_mdv
//  Brief    : Directed, table-driven self-checking bench for exu_mdv.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_exu_mdv;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs_ex4md_val;
    logic        hs_md4ex_rdy;
    logic [2:0]  i_mdv_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [4:0]  i_rd_idx;
    logic        i_flush;
    logic        hs_md4wb_val;
    logic        hs_wb4md_rdy;
    logic [31:0] o_rd;
    logic [4:0]  o_rd_idx;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_mdv #(.XLEN(32), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .hs_ex4md_val (hs_ex4md_val),
        .hs_md4ex_rdy (hs_md4ex_rdy),
        .i_mdv_op     (i_mdv_op),
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .i_rd_idx     (i_rd_idx),
        .i_flush      (i_flush),
        .hs_md4wb_val (hs_md4wb_val),
        .hs_wb4md_rdy (hs_wb4md_rdy),
        .o_rd         (o_rd),
        .o_rd_idx     (o_rd_idx),
        .o_busy       (o_busy)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept counts as edge 1; DONE must be visible after edge 'lat'.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] idx,
                          input logic [31:0] exp, input int lat, input bit finish);
        int n;
        @(negedge clk);
        chk({name, "_rdy"}, {31'd0, hs_md4ex_rdy}, 32'd1);
        hs_ex4md_val = 1'b1;
        i_mdv_op     = op;
        i_rs1        = a;
        i_rs2        = b;
        i_rd_idx     = idx;
        @(posedge clk); #1;
        hs_ex4md_val = 1'b0;
        n = 1;
        while (!hs_md4wb_val && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_rd"}, o_rd, exp);
        chk({name, "_idx"}, {27'd0, o_rd_idx}, {27'd0, idx});
        if (finish) begin
            @(posedge clk); #1;
            chk({name, "_valdrop"}, {31'd0, hs_md4wb_val}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] held_rd;
        vecs[0]  = '{"mul",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{"mulh",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[2]  = '{"mulhsu",   3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 34};
        vecs[3]  = '{"mulhu",    3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[4]  = '{"mulhu_ff", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[5]  = '{"mul_big",  3'd0, 32'h00010001, 32'h00010001, 32'h00020001, 34};
        vecs[6]  = '{"div",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[7]  = '{"rem",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[8]  = '{"div_nd",   3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[9]  = '{"rem_nd",   3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
        vecs[10] = '{"divu",     3'd5, 32'd100,      32'd7,        32'd14,       34};
        vecs[11] = '{"remu",     3'd7, 32'd100,      32'd7,        32'd2,        34};
        vecs[12] = '{"divu_z",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{"rem_z",    3'd6, 32'd5,        32'd0,        32'd5,        1};
        vecs[14] = '{"div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[15] = '{"rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

        rst = 1'b1; hs_ex4md_val = 1'b0; i_mdv_op = '0; i_rs1 = '0; i_rs2 = '0;
        i_rd_idx = '0; i_flush = 1'b0; hs_wb4md_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val",  {31'd0, hs_md4wb_val}, 32'd0);
        chk("rst_rdy",  {31'd0, hs_md4ex_rdy}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_rd",   o_rd, 32'd0);
        chk("rst_idx",  {27'd0, o_rd_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
                   vecs[i].exp, vecs[i].lat, 1'b1);

        // back-pressure: DONE must hold steady while write-back stalls
        hs_wb4md_rdy = 1'b0;
        run_op("bp", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd9, 32'hFFFFFFEB, 34, 1'b0);
        held_rd = o_rd;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_val",  {31'd0, hs_md4wb_val}, 32'd1);
            chk("bp_rd",   o_rd, 32'hFFFFFFEB);
            chk("bp_idx",  {27'd0, o_rd_idx}, 32'd9);
            chk("bp_rdy",  {31'd0, hs_md4ex_rdy}, 32'd0);
        end
        @(negedge clk);
        hs_wb4md_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_val", {31'd0, hs_md4wb_val}, 32'd0);
        chk("bp_rel_rdy", {31'd0, hs_md4ex_rdy}, 32'd1);
        run_op("after_bp", 3'd5, 32'd100, 32'd7, 5'd10, 32'd14, 34, 1'b1);

        // flush at counter 10
        @(negedge clk);
        hs_ex4md_val = 1'b1; i_mdv_op = 3'd5; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_rd_idx = 5'd11;
        @(posedge clk); #1;
        hs_ex4md_val = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("fl_busy_pre", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("fl_busy", {31'd0, o_busy}, 32'd0);
        chk("fl_val",  {31'd0, hs_md4wb_val}, 32'd0);
        chk("fl_rdy",  {31'd0, hs_md4ex_rdy}, 32'd1);
        begin
            int seen = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (hs_md4wb_val) seen++;
            end
            chk("fl_noval", 32'(seen), 32'd0);
        end

        // reset in the middle of CALC
        @(negedge clk);
        hs_ex4md_val = 1'b1; i_mdv_op = 3'd0; i_rs1 = 32'd5; i_rs2 = 32'd6; i_rd_idx = 5'd12;
        @(posedge clk); #1;
        hs_ex4md_val = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mr_val",  {31'd0, hs_md4wb_val}, 32'd0);
        chk("mr_busy", {31'd0, o_busy}, 32'd0);
        chk("mr_rdy",  {31'd0, hs_md4ex_rdy}, 32'd0);
        chk("mr_rd",   o_rd, 32'd0);
        chk("mr_idx",  {27'd0, o_rd_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'd0, 34, 1'b1);
        run_op("post_rst2", 3'd0, 32'd12345, 32'd1000, 5'd14, 32'd12345000, 34, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
